// File: rtl/spi_pkg.sv
// Shared types and mode-decode helpers for the single-CS SPI master.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package spi_pkg;

    // Frame-level control states of the chip-select sequencer.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        CS_HOLD = 2'd2
    } state_t;

    // One byte is 8 leading plus 8 trailing SCLK edges.
    localparam int EDGES_PER_BYTE = 16;

    // Idle level of SCLK for a given SPI mode.
    function automatic logic cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    // 0: sample on the leading edge, 1: sample on the trailing edge.
    function automatic logic cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_master_core.sv
// SCLK edge generator plus TX/RX shift registers for one byte; no chip-select handling.
// Latency: done_o is high in the cycle 17*CLKS_PER_HALF_BIT cycles after start_i is taken.
// Backpressure: start_i is ignored while a byte is in flight. Bit order set by SPI_LSB_FIRST_EN.
module spi_master_core
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
)
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    input  logic       miso_i,
    output logic       done_o,
    output logic [7:0] rx_byte_o,
    output logic       sclk_o,
    output logic       mosi_o
);

    localparam logic CPOL = cpol(2'(SPI_MODE));
    localparam logic CPHA = cpha(2'(SPI_MODE));
    localparam int   CNT_W = $clog2(CLKS_PER_HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [4:0] EDGE_END  = 5'(EDGES_PER_BYTE);
    localparam logic [4:0] EDGE_LAST = 5'(EDGES_PER_BYTE - 1);

`ifdef SPI_LSB_FIRST_EN
    function automatic logic first_bit(input logic [7:0] b);
        return b[0];
    endfunction
    function automatic logic [7:0] shift_out(input logic [7:0] b);
        return {1'b0, b[7:1]};
    endfunction
    function automatic logic [7:0] shift_in(input logic [7:0] b, input logic bit_in);
        return {bit_in, b[7:1]};
    endfunction
`else
    function automatic logic first_bit(input logic [7:0] b);
        return b[7];
    endfunction
    function automatic logic [7:0] shift_out(input logic [7:0] b);
        return {b[6:0], 1'b0};
    endfunction
    function automatic logic [7:0] shift_in(input logic [7:0] b, input logic bit_in);
        return {b[6:0], bit_in};
    endfunction
`endif

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       edge_q, edge_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;

    logic tick;
    logic leading;

    // A tick every half bit; ticks 1..16 are SCLK edges, tick 17 closes the frame.
    assign tick    = busy_q && (cnt_q == CNT_LAST);
    assign leading = ~edge_q[0];
    assign done_o  = tick && (edge_q == EDGE_END);

    // Next-state: load on start, then toggle SCLK and shift on each tick.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        edge_d = edge_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        if (start_i && !busy_q) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            edge_d = '0;
            tx_d   = tx_byte_i;
            rx_d   = '0;
            sclk_d = CPOL;
            // With CPHA=0 the first bit must already be on the wire when CS falls.
            if (!CPHA) begin
                mosi_d = first_bit(tx_byte_i);
            end
        end else if (busy_q) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                if (edge_q == EDGE_END) begin
                    busy_d = 1'b0;
                end else begin
                    edge_d = edge_q + 1'b1;
                    sclk_d = ~sclk_q;
                    if (leading) begin
                        if (CPHA) begin
                            mosi_d = first_bit(tx_q);
                            tx_d   = shift_out(tx_q);
                        end else begin
                            rx_d = shift_in(rx_q, miso_i);
                        end
                    end else begin
                        if (CPHA) begin
                            rx_d = shift_in(rx_q, miso_i);
                        end else if (edge_q != EDGE_LAST) begin
                            // Last trailing edge has no next bit: MOSI keeps its value.
                            tx_d   = shift_out(tx_q);
                            mosi_d = first_bit(shift_out(tx_q));
                        end
                    end
                end
            end
        end
    end

    // State register with synchronous reset; SCLK returns to its idle level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            edge_q <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            sclk_q <= CPOL;
            mosi_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
        end
    end

    assign rx_byte_o = rx_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;

endmodule

// File: rtl/spi_master_with_single_cs.sv
// SPI master, one active-low CS, one full-duplex byte per CS frame (SPI_LSB_FIRST_EN: LSB first).
// Latency: CS low 17*CLKS_PER_HALF_BIT cycles after accept; o_RX_DV in the cycle CS rises.
// Backpressure: o_TX_Ready low from accept until CS has been high CS_INACTIVE_CLKS cycles; no queuing.
module spi_master_with_single_cs
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_INACTIVE_CLKS  = 1
)
(
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_DV,
    output logic       o_SPI_Clk,
    output logic       o_SPI_MOSI,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_CS_n
);

    localparam int HOLD_W = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_INACTIVE_CLKS - 1);

    state_t            state_q, state_d;
    logic              cs_n_q, cs_n_d;
    logic              ready_q, ready_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic              rx_dv_q, rx_dv_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic       tx_accept;
    logic       core_done;
    logic [7:0] core_rx;

    // Ready is registered, so a request is only taken when the host can see ready.
    assign tx_accept = ready_q && i_TX_DV;

    spi_master_core #(
        .SPI_MODE          (SPI_MODE),
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
    ) u_core (
        .clk_i     (i_Clk),
        .rst_i     (i_Rst),
        .start_i   (tx_accept),
        .tx_byte_i (i_TX_Byte),
        .miso_i    (i_SPI_MISO),
        .done_o    (core_done),
        .rx_byte_o (core_rx),
        .sclk_o    (o_SPI_Clk),
        .mosi_o    (o_SPI_MOSI)
    );

    // Frame sequencer: drop CS on accept, raise it with the RX strobe, then hold it high.
    always_comb begin
        state_d   = state_q;
        cs_n_d    = cs_n_q;
        rx_byte_d = rx_byte_q;
        rx_dv_d   = 1'b0;
        hold_d    = hold_q;
        case (state_q)
            IDLE: begin
                if (tx_accept) begin
                    state_d = XFER;
                    cs_n_d  = 1'b0;
                end
            end
            XFER: begin
                if (core_done) begin
                    state_d   = CS_HOLD;
                    cs_n_d    = 1'b1;
                    rx_dv_d   = 1'b1;
                    rx_byte_d = core_rx;
                    hold_d    = '0;
                end
            end
            CS_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // Sequencer registers; reset aborts any frame without an RX strobe.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            cs_n_q    <= 1'b1;
            ready_q   <= 1'b0;
            rx_byte_q <= '0;
            rx_dv_q   <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            cs_n_q    <= cs_n_d;
            ready_q   <= ready_d;
            rx_byte_q <= rx_byte_d;
            rx_dv_q   <= rx_dv_d;
            hold_q    <= hold_d;
        end
    end

    assign o_TX_Ready = ready_q;
    assign o_RX_Byte  = rx_byte_q;
    assign o_RX_DV    = rx_dv_q;
    assign o_SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_with_single_cs.sv
// Directed bench: four masters (modes 0..3) share stimulus; mode 3 can talk to a slave model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_master_with_single_cs;

`ifdef SPI_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_byte;
    logic       tx_dv;
    logic       loop_en;
    logic       mon_clr;

    logic [3:0] ready, rx_dv, sclk, mosi, miso, cs_n;
    logic [7:0] rx_byte [4];

    logic [7:0] sl_tx, sl_rx;
    logic       sl_miso;

    int checks   = 0;
    int failures = 0;

    int         edges [4];
    int         bad_edges [4];
    int         rxdv_cnt [4];
    int         falls [4];
    logic [7:0] rx_last [4];
    logic       first_mosi [4];
    logic [3:0] prev_sclk, prev_cs;
    logic       prev_rdy0;
    int cyc, cs_rise_t, ready_delay, cs_low_run, cs_low_len, cs_high_run, min_gap;

    always #5 clk = ~clk;

    assign sl_miso = LSB ? sl_tx[0] : sl_tx[7];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_master_with_single_cs #(
            .SPI_MODE          (g),
            .CLKS_PER_HALF_BIT (2),
            .CS_INACTIVE_CLKS  (1)
        ) u_dut (
            .i_Clk      (clk),
            .i_Rst      (rst),
            .i_TX_Byte  (tx_byte),
            .i_TX_DV    (tx_dv),
            .o_TX_Ready (ready[g]),
            .o_RX_Byte  (rx_byte[g]),
            .o_RX_DV    (rx_dv[g]),
            .o_SPI_Clk  (sclk[g]),
            .o_SPI_MOSI (mosi[g]),
            .i_SPI_MISO (miso[g]),
            .o_SPI_CS_n (cs_n[g])
        );
        assign miso[g] = (g == 3 && !loop_en) ? sl_miso : mosi[g];
    end

    function automatic logic exp_cpol(input int m);
        return (m >= 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor and mode-3 slave, sampled 1 time unit after each rising clock edge.
    initial begin
        cyc = 0;
        sl_tx = 8'hA5;
        sl_rx = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (cs_n[3] === 1'b1) begin
                sl_tx = 8'hA5;
            end else if (sclk[3] === 1'b1 && prev_sclk[3] === 1'b0) begin
                sl_rx = LSB ? {mosi[3], sl_rx[7:1]} : {sl_rx[6:0], mosi[3]};
                sl_tx = LSB ? {1'b0, sl_tx[7:1]} : {sl_tx[6:0], 1'b0};
            end
            if (mon_clr) begin
                for (int m = 0; m < 4; m++) begin
                    edges[m] = 0; bad_edges[m] = 0; rxdv_cnt[m] = 0; falls[m] = 0;
                    rx_last[m] = 8'h00; first_mosi[m] = 1'bx;
                end
                sl_rx = 8'h00;
                cs_rise_t = 0; ready_delay = -1; cs_low_run = 0; cs_low_len = 0;
                cs_high_run = 0; min_gap = 999;
            end else begin
                for (int m = 0; m < 4; m++) begin
                    if (sclk[m] !== prev_sclk[m]) begin
                        if (cs_n[m]) bad_edges[m]++;
                        else         edges[m]++;
                    end
                    if (rx_dv[m] === 1'b1) begin
                        rxdv_cnt[m]++;
                        rx_last[m] = rx_byte[m];
                    end
                    if (prev_cs[m] === 1'b1 && cs_n[m] === 1'b0) begin
                        falls[m]++;
                        first_mosi[m] = mosi[m];
                    end
                end
                if (cs_n[0] === 1'b0) begin
                    if (prev_cs[0] === 1'b1 && falls[0] > 1 && cs_high_run < min_gap)
                        min_gap = cs_high_run;
                    cs_low_run++;
                    cs_high_run = 0;
                end else begin
                    if (prev_cs[0] === 1'b0) begin
                        cs_low_len = cs_low_run;
                        cs_low_run = 0;
                        cs_rise_t  = cyc;
                    end
                    cs_high_run++;
                end
                if (ready[0] === 1'b1 && prev_rdy0 === 1'b0)
                    ready_delay = cyc - cs_rise_t;
            end
            prev_sclk = sclk;
            prev_cs   = cs_n;
            prev_rdy0 = ready[0];
        end
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic wait_ready(input int limit);
        int n;
        n = 0;
        while (ready[0] !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("ready_within_bound", {31'd0, ready[0]}, 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready(100);
        tx_byte = b;
        tx_dv   = 1'b1;
        @(negedge clk);
        tx_dv   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tx_dv = 1'b0; tx_byte = 8'h00; loop_en = 1'b1; mon_clr = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("rst_cs_n_m%0d", m), {31'd0, cs_n[m]}, 32'd1);
            chk($sformatf("rst_sclk_m%0d", m), {31'd0, sclk[m]}, {31'd0, exp_cpol(m)});
            chk($sformatf("rst_ready_m%0d", m), {31'd0, ready[m]}, 32'd0);
        end
        chk("rst_mosi", {31'd0, mosi[0]}, 32'd0);
        chk("rst_rx_dv", {31'd0, rx_dv[0]}, 32'd0);
        chk("rst_rx_byte", {24'd0, rx_byte[0]}, 32'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", {31'd0, ready[0]}, 32'd1);

        // Mode 3 against a slave returning A5
        loop_en = 1'b0;
        clear_mon();
        send(8'hC1);
        wait_ready(100);
        chk("m3_rx_byte", {24'd0, rx_last[3]}, 32'hA5);
        chk("m3_rx_dv_count", rxdv_cnt[3], 1);
        chk("m3_slave_rx", {24'd0, sl_rx}, 32'hC1);
        chk("m3_edges", edges[3], 16);
        chk("m3_sclk_idle", {31'd0, sclk[3]}, 32'd1);
        loop_en = 1'b1;

        // Loopback 3C in all modes
        clear_mon();
        send(8'h3C);
        wait_ready(100);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("lb_rx_m%0d", m), {24'd0, rx_last[m]}, 32'h3C);
            chk($sformatf("lb_dv_m%0d", m), rxdv_cnt[m], 1);
            chk($sformatf("lb_edges_m%0d", m), edges[m], 16);
            chk($sformatf("lb_bad_edges_m%0d", m), bad_edges[m], 0);
            chk($sformatf("lb_sclk_idle_m%0d", m), {31'd0, sclk[m]}, {31'd0, exp_cpol(m)});
        end

        // Back-to-back 55 then AA, frame length and CS gap
        clear_mon();
        send(8'h55);
        send(8'hAA);
        wait_ready(100);
        chk("b2b_cs_low_len", cs_low_len, 34);
        chk("b2b_ready_delay", ready_delay, 1);
        chk("b2b_frames", falls[0], 2);
        chk("b2b_gap_ge1", {31'd0, (min_gap >= 1 && min_gap < 999)}, 32'd1);
        chk("b2b_dv_count", rxdv_cnt[0], 2);
        chk("b2b_rx_last", {24'd0, rx_last[0]}, 32'hAA);

        // Request while busy is ignored
        clear_mon();
        send(8'h96);
        repeat (10) @(negedge clk);
        tx_byte = 8'hFF;
        tx_dv   = 1'b1;
        @(negedge clk);
        tx_dv   = 1'b0;
        wait_ready(100);
        repeat (5) @(negedge clk);
        chk("busy_frames", falls[0], 1);
        chk("busy_dv_count", rxdv_cnt[0], 1);
        chk("busy_rx", {24'd0, rx_last[0]}, 32'h96);

        // Reset at edge 7 of a frame
        clear_mon();
        send(8'h5A);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_edges_before", edges[0], 6);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("abort_cs_n_m%0d", m), {31'd0, cs_n[m]}, 32'd1);
            chk($sformatf("abort_sclk_m%0d", m), {31'd0, sclk[m]}, {31'd0, exp_cpol(m)});
        end
        rst = 1'b0;
        repeat (40) @(negedge clk);
        for (int m = 0; m < 4; m++)
            chk($sformatf("abort_no_dv_m%0d", m), rxdv_cnt[m], 0);
        clear_mon();
        send(8'h81);
        wait_ready(100);
        chk("post_abort_rx", {24'd0, rx_last[0]}, 32'h81);
        chk("post_abort_dv", rxdv_cnt[0], 1);
        chk("post_abort_edges", edges[1], 16);

        // First bit on the wire and loopback of 01
        clear_mon();
        send(8'h01);
        wait_ready(100);
        chk("first_mosi_m0", {31'd0, first_mosi[0]}, {31'd0, LSB});
        chk("first_mosi_m2", {31'd0, first_mosi[2]}, {31'd0, LSB});
        for (int m = 0; m < 4; m++)
            chk($sformatf("lb01_rx_m%0d", m), {24'd0, rx_last[m]}, 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
